weight_row_fetcher: RTL

Read-side master for the off-chip synaptic weight RAM. On a single-cycle start command it reads a contiguous row of `RowLength` words beginning at `RowBase`. It drives the RAM's chip-enable/address port, absorbs the RAM's one-cycle registered-address latency, and streams the words to the neuron update logic over a valid/ready handshake with full backpressure. It sits between the synaptic-event scheduler, which issues rows, and the weight RAM's read port.

---
 rtl/weight_row_fetcher_pkg.sv | 14 +
 rtl/weight_row_fetcher_if.sv | 32 +++
 rtl/weight_row_fetcher_out_stage.sv | 43 ++++
 rtl/weight_row_fetcher.sv | 90 +++++++++
 4 files changed

// File: rtl/weight_row_fetcher_pkg.sv
// Shared constants and FSM state encoding for the synaptic weight memory path.
package cynapse_mem_pkg;

   localparam int DEF_WORD_WIDTH = 48;
   localparam int DEF_ADDR_WIDTH = 23;
   localparam int DEF_LEN_WIDTH  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/weight_row_fetcher_if.sv
// Row-request, RAM read port and weight stream bundle; master is the fetcher side.
interface weight_row_fetcher_if import cynapse_mem_pkg::*; #(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
   logic                  Start;
   logic [ADDR_WIDTH-1:0] RowBase;
   logic [LEN_WIDTH-1:0]  RowLength;
   logic                  Busy;
   logic                  Done;
   logic                  RamChipEnable;
   logic                  RamWriteEnable;
   logic [ADDR_WIDTH-1:0] RamAddress;
   logic [WORD_WIDTH-1:0] RamData;
   logic                  WeightValid;
   logic                  WeightReady;
   logic [WORD_WIDTH-1:0] WeightData;
   logic                  WeightLast;

   modport master (
      input  Start, RowBase, RowLength, RamData, WeightReady,
      output Busy, Done, RamChipEnable, RamWriteEnable, RamAddress,
      output WeightValid, WeightData, WeightLast
   );

   modport slave (
      output Start, RowBase, RowLength, RamData, WeightReady,
      input  Busy, Done, RamChipEnable, RamWriteEnable, RamAddress,
      input  WeightValid, WeightData, WeightLast
   );
endinterface

// File: rtl/weight_row_fetcher_out_stage.sv
// One-entry output register: captures the in-flight RAM word when the slot is free
// or being drained this cycle.
module weight_out_stage import cynapse_mem_pkg::*; #(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_inflight,
   input  logic [WORD_WIDTH-1:0] i_data,
   input  logic                  i_last,
   input  logic                  i_ready,
   output logic                  o_load,
   output logic                  o_valid,
   output logic [WORD_WIDTH-1:0] o_data,
   output logic                  o_last
);
   logic                  r_valid;
   logic                  r_last;
   logic [WORD_WIDTH-1:0] r_data;
   logic                  w_load;

   assign w_load  = i_inflight & (~r_valid | i_ready);
   assign o_load  = w_load;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;

   // Output slot: load wins over a plain handshake, which only empties the slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= {WORD_WIDTH{1'b0}};
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_last  <= i_last;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end
endmodule

// File: rtl/weight_row_fetcher.sv
// Reads a contiguous row from the weight RAM and streams it out with full
// backpressure, hiding the RAM's one-cycle read latency.
module weight_row_fetcher import cynapse_mem_pkg::*; #(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input logic                  Clock,
   input logic                  Reset,
   weight_row_fetcher_if.master bus
);
   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_issue_left;
   logic [LEN_WIDTH-1:0]  r_deliver_left;
   logic                  r_inflight;
   logic                  w_load;
   logic                  w_issue;
   logic                  w_load_last;
   logic                  w_last_hs;

   // A new read may only be issued when the RAM output register is free or is being captured now.
   assign w_issue     = (r_state == ST_RUN) && (r_issue_left != LEN_WIDTH'(0)) &&
                        (!r_inflight || w_load);
   assign w_load_last = (r_deliver_left == LEN_WIDTH'(1));
   assign w_last_hs   = bus.WeightValid & bus.WeightReady & bus.WeightLast;

   assign bus.Busy           = (r_state != ST_IDLE);
   assign bus.Done           = (r_state == ST_DONE);
   assign bus.RamChipEnable  = w_issue;
   assign bus.RamWriteEnable = 1'b0;
   assign bus.RamAddress     = r_addr;

   weight_out_stage #(.WORD_WIDTH(WORD_WIDTH)) u_out (
      .i_clk      (Clock),
      .i_rst      (Reset),
      .i_inflight (r_inflight),
      .i_data     (bus.RamData),
      .i_last     (w_load_last),
      .i_ready    (bus.WeightReady),
      .o_load     (w_load),
      .o_valid    (bus.WeightValid),
      .o_data     (bus.WeightData),
      .o_last     (bus.WeightLast)
   );

   // Row FSM with issue/delivery counters and the in-flight tracker.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state        <= ST_IDLE;
         r_addr         <= {ADDR_WIDTH{1'b0}};
         r_issue_left   <= {LEN_WIDTH{1'b0}};
         r_deliver_left <= {LEN_WIDTH{1'b0}};
         r_inflight     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_inflight <= 1'b0;
               if (bus.Start) begin
                  r_addr         <= bus.RowBase;
                  r_issue_left   <= bus.RowLength;
                  r_deliver_left <= bus.RowLength;
                  r_state        <= (bus.RowLength != LEN_WIDTH'(0)) ? ST_RUN : ST_DONE;
               end
            end
            ST_RUN: begin
               if (w_issue) begin
                  r_addr       <= r_addr + ADDR_WIDTH'(1);
                  r_issue_left <= r_issue_left - LEN_WIDTH'(1);
               end
               if (w_load) begin
                  r_deliver_left <= r_deliver_left - LEN_WIDTH'(1);
               end
               r_inflight <= w_issue | (r_inflight & ~w_load);
               if (w_last_hs) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_inflight <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_inflight <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
